// File: rtl/wb_mux_timed_pkg.sv
// Shared definitions for the timed Wishbone mux: FSM states, response kinds,
// error-cause codes and a helper for the slave-index width.
package wb_mux_timed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_ACK  = 2'd1,
        RESP_ERR  = 2'd2,
        RESP_RTY  = 2'd3
    } resp_t;

    typedef enum logic [1:0] {
        CAUSE_NONE     = 2'd0,
        CAUSE_SLAVE    = 2'd1,
        CAUSE_UNMAPPED = 2'd2,
        CAUSE_TIMEOUT  = 2'd3
    } err_cause_t;

    // Width of a slave index; a single-slave build still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Address decoder: mask match against every slave window, lowest index wins
// when windows overlap.
module wb_addr_decode
    import wb_mux_timed_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       AW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
    parameter int                       IW         = idx_width(NUM_SLAVES)
) (
    input  logic [AW-1:0] adr,
    output logic          hit,
    output logic [IW-1:0] idx
);

    // Scan from the top index down so the lowest matching slave is the last writer.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((adr & MATCH_MASK[i*AW +: AW]) ==
                (MATCH_ADDR[i*AW +: AW] & MATCH_MASK[i*AW +: AW])) begin
                hit = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/wb_mux_timed.sv
// Single-master, N-slave Wishbone classic interconnect with response timeout.
// One transaction in flight at a time: IDLE decodes and latches the request,
// BUSY strobes the chosen slave and waits for ack/err/rty (or the timer),
// RESP returns exactly one registered response pulse to the master.
//
// Handshake: the master presents a request with cyc&stb and keeps cyc high
// until it sees a one-cycle ack/err/rty pulse; dropping cyc while BUSY aborts
// the access silently. Toward the slave, stb/cyc are held for the whole BUSY
// phase and the first cycle with ack/err/rty (err > rty > ack) completes it.
//
// Optional build macro WB_MUX_ERRLATCH_EN adds err_adr_o/err_cause_o, which
// record the address and cause of the most recent error response.
module wb_mux_timed
    import wb_mux_timed_pkg::*;
#(
    parameter int                       NUM_SLAVES = 4,
    parameter int                       AW         = 32,
    parameter int                       DW         = 32,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_ADDR = '0,
    parameter logic [NUM_SLAVES*AW-1:0] MATCH_MASK = '0,
    parameter int                       TIMEOUT    = 255,
    parameter int                       TO_BITS    = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [AW-1:0]                wbm_adr_i,
    input  logic [DW-1:0]                wbm_dat_i,
    output logic [DW-1:0]                wbm_dat_o,
    input  logic                         wbm_we_i,
    input  logic [DW/8-1:0]              wbm_sel_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_cyc_i,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    output logic                         wbm_rty_o,
    output logic [NUM_SLAVES*AW-1:0]     wbs_adr_o,
    output logic [NUM_SLAVES*DW-1:0]     wbs_dat_o,
    input  logic [NUM_SLAVES*DW-1:0]     wbs_dat_i,
    output logic [NUM_SLAVES-1:0]        wbs_we_o,
    output logic [NUM_SLAVES*(DW/8)-1:0] wbs_sel_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    input  logic [NUM_SLAVES-1:0]        wbs_rty_i,
`ifdef WB_MUX_ERRLATCH_EN
    output logic [AW-1:0]                err_adr_o,
    output logic [1:0]                   err_cause_o,
`endif
    output logic [1:0]                   dbg_state
);

    localparam int SW = DW / 8;
    localparam int IW = idx_width(NUM_SLAVES);

    state_t       state;
    state_t       state_next;
    resp_t        resp_next;
    err_cause_t   cause_next;

    logic          dec_hit;
    logic [IW-1:0] dec_idx;
    logic [IW-1:0] idx_q;
    logic [AW-1:0] adr_q;
    logic [DW-1:0] dat_q;
    logic          we_q;
    logic [SW-1:0] sel_q;
    logic [TO_BITS-1:0] timer;

    logic          req;
    logic          sel_ack;
    logic          sel_err;
    logic          sel_rty;
    logic [DW-1:0] sel_dat;
    logic          timeout_hit;

    wb_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .AW         (AW),
        .MATCH_ADDR (MATCH_ADDR),
        .MATCH_MASK (MATCH_MASK),
        .IW         (IW)
    ) u_decode (
        .adr (wbm_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign req         = wbm_cyc_i & wbm_stb_i;
    assign sel_ack     = wbs_ack_i[idx_q];
    assign sel_err     = wbs_err_i[idx_q];
    assign sel_rty     = wbs_rty_i[idx_q];
    assign sel_dat     = wbs_dat_i[idx_q*DW +: DW];
    assign timeout_hit = (TIMEOUT != 0) && (timer == TO_BITS'(TIMEOUT - 1));
    assign dbg_state   = state;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next state plus the response kind and error cause to present in RESP.
    always_comb begin
        state_next = state;
        resp_next  = RESP_NONE;
        cause_next = CAUSE_NONE;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (dec_hit) begin
                        state_next = ST_BUSY;
                    end else begin
                        state_next = ST_RESP;
                        resp_next  = RESP_ERR;
                        cause_next = CAUSE_UNMAPPED;
                    end
                end
            end
            ST_BUSY: begin
                if (!wbm_cyc_i) begin
                    state_next = ST_IDLE;
                end else if (sel_err) begin
                    state_next = ST_RESP;
                    resp_next  = RESP_ERR;
                    cause_next = CAUSE_SLAVE;
                end else if (sel_rty) begin
                    state_next = ST_RESP;
                    resp_next  = RESP_RTY;
                end else if (sel_ack) begin
                    state_next = ST_RESP;
                    resp_next  = RESP_ACK;
                end else if (timeout_hit) begin
                    state_next = ST_RESP;
                    resp_next  = RESP_ERR;
                    cause_next = CAUSE_TIMEOUT;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture the request fields when a new access is accepted in IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            we_q  <= 1'b0;
            sel_q <= '0;
        end else if (state == ST_IDLE && req) begin
            idx_q <= dec_idx;
            adr_q <= wbm_adr_i;
            dat_q <= wbm_dat_i;
            we_q  <= wbm_we_i;
            sel_q <= wbm_sel_i;
        end
    end

    // Cycle counter for the BUSY phase; cleared whenever the mux is not waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 timer <= '0;
        else if (state == ST_BUSY) timer <= timer + TO_BITS'(1);
        else                       timer <= '0;
    end

    // Response pulses are registered so they coincide with the RESP cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
        end else begin
            wbm_ack_o <= (resp_next == RESP_ACK);
            wbm_err_o <= (resp_next == RESP_ERR);
            wbm_rty_o <= (resp_next == RESP_RTY);
        end
    end

    // Read data is taken from the selected slave on any real slave response and then held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wbm_dat_o <= '0;
        end else if (state == ST_BUSY && wbm_cyc_i && (sel_ack || sel_err || sel_rty)) begin
            wbm_dat_o <= sel_dat;
        end
    end

    // Only the selected slave sees stb/cyc, and only while BUSY.
    always_comb begin
        wbs_stb_o = '0;
        wbs_cyc_o = '0;
        if (state == ST_BUSY) begin
            wbs_stb_o[idx_q] = 1'b1;
            wbs_cyc_o[idx_q] = 1'b1;
        end
    end

    assign wbs_adr_o = {NUM_SLAVES{adr_q}};
    assign wbs_dat_o = {NUM_SLAVES{dat_q}};
    assign wbs_we_o  = {NUM_SLAVES{we_q}};
    assign wbs_sel_o = {NUM_SLAVES{sel_q}};

`ifdef WB_MUX_ERRLATCH_EN
    // Record address and cause of every error response; unmapped errors use the live address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_adr_o   <= '0;
            err_cause_o <= '0;
        end else if (resp_next == RESP_ERR) begin
            err_adr_o   <= (state == ST_IDLE) ? wbm_adr_i : adr_q;
            err_cause_o <= cause_next;
        end
    end
`else
    // The cause code is only consumed by the error latch.
    logic unused_cause;
    assign unused_cause = ^cause_next;
`endif

endmodule

// File: tb/tb_wb_mux_timed.sv
// Directed bench for wb_mux_timed: a driver issues accesses and pushes the
// expected response onto a queue; a monitor pops and compares on every
// ack/err/rty pulse. Slave behaviour is set per test through mode[].
module tb_wb_mux_timed;

    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [NS*AW-1:0] M_ADDR = {32'h0000_0100, 32'h0000_2000, 32'h0000_2000, 32'h0000_1000};
    localparam logic [NS*AW-1:0] M_MASK = {32'hFFFF_FF00, 32'hFFFF_E000, 32'hFFFF_F000, 32'hFFFF_F000};

    localparam logic [2:0] K_ACK = 3'b001;
    localparam logic [2:0] K_RTY = 3'b010;
    localparam logic [2:0] K_ERR = 3'b100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // ---------------- DUT signals ----------------
    logic [AW-1:0]      adr_m = '0;
    logic [DW-1:0]      dat_m = '0;
    logic               we_m  = 1'b0;
    logic [DW/8-1:0]    sel_m = 4'hF;
    logic               stb   = 1'b0;
    logic               cyc   = 1'b0;
    logic [DW-1:0]      wbm_dat_o;
    logic               wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic [NS*AW-1:0]   wbs_adr_o;
    logic [NS*DW-1:0]   wbs_dat_o;
    logic [NS*DW-1:0]   wbs_dat_i;
    logic [NS-1:0]      wbs_we_o;
    logic [NS*DW/8-1:0] wbs_sel_o;
    logic [NS-1:0]      wbs_stb_o, wbs_cyc_o;
    logic [NS-1:0]      wbs_ack_i, wbs_err_i, wbs_rty_i;
    logic [1:0]         dbg_state;
`ifdef WB_MUX_ERRLATCH_EN
    logic [AW-1:0]      err_adr;
    logic [1:0]         err_cause;
`endif

    wb_mux_timed #(
        .NUM_SLAVES (NS),
        .AW         (AW),
        .DW         (DW),
        .MATCH_ADDR (M_ADDR),
        .MATCH_MASK (M_MASK),
        .TIMEOUT    (8),
        .TO_BITS    (8)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .wbm_adr_i (adr_m),
        .wbm_dat_i (dat_m),
        .wbm_dat_o (wbm_dat_o),
        .wbm_we_i  (we_m),
        .wbm_sel_i (sel_m),
        .wbm_stb_i (stb),
        .wbm_cyc_i (cyc),
        .wbm_ack_o (wbm_ack_o),
        .wbm_err_o (wbm_err_o),
        .wbm_rty_o (wbm_rty_o),
        .wbs_adr_o (wbs_adr_o),
        .wbs_dat_o (wbs_dat_o),
        .wbs_dat_i (wbs_dat_i),
        .wbs_we_o  (wbs_we_o),
        .wbs_sel_o (wbs_sel_o),
        .wbs_stb_o (wbs_stb_o),
        .wbs_cyc_o (wbs_cyc_o),
        .wbs_ack_i (wbs_ack_i),
        .wbs_err_i (wbs_err_i),
        .wbs_rty_i (wbs_rty_i),
`ifdef WB_MUX_ERRLATCH_EN
        .err_adr_o   (err_adr),
        .err_cause_o (err_cause),
`endif
        .dbg_state (dbg_state)
    );

    // ---------------- slave models ----------------
    // mode: 0 ack at once, 1 never respond, 2 err+ack together, 3 retry, 4 ack after 2 waits
    logic [2:0] mode [NS];
    logic [NS-1:0] spur_ack = '0;
    logic [NS-1:0] s_ack, s_err, s_rty;
    int wcnt = 0;

    function automatic logic [31:0] rdata(input int i);
        case (i)
            0:       return 32'hDEAD_BEEF;
            1:       return 32'h1111_1111;
            2:       return 32'h2222_2222;
            default: return 32'h3333_3333;
        endcase
    endfunction

    assign wbs_dat_i = {rdata(3), rdata(2), rdata(1), rdata(0)};

    always @(posedge clk) wcnt <= wbs_stb_o[0] ? wcnt + 1 : 0;

    always_comb begin
        s_ack = '0;
        s_err = '0;
        s_rty = '0;
        for (int i = 0; i < NS; i++) begin
            if (wbs_cyc_o[i] && wbs_stb_o[i]) begin
                case (mode[i])
                    3'd0: s_ack[i] = 1'b1;
                    3'd2: begin s_ack[i] = 1'b1; s_err[i] = 1'b1; end
                    3'd3: s_rty[i] = 1'b1;
                    3'd4: s_ack[i] = (wcnt >= 2);
                    default: ;
                endcase
            end
        end
        s_ack = s_ack | spur_ack;
    end

    assign wbs_ack_i = s_ack;
    assign wbs_err_i = s_err;
    assign wbs_rty_i = s_rty;

    // ---------------- scoreboard ----------------
    // item = {kind[2:0], latency[7:0], data[31:0]}
    logic [42:0] exp_q[$];
    int errors = 0;
    int checks = 0;
    int req_cnt = 0;
    logic [31:0] exp_held = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every response pulse must match the head of the expected queue.
    always @(negedge clk) begin
        logic [42:0] item;
        int lat;
        if (!rst && (wbm_ack_o || wbm_err_o || wbm_rty_o)) begin
            checks++;
            lat = cyc_cnt - req_cnt;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got kind=%b dat=%h with nothing expected",
                         {wbm_err_o, wbm_rty_o, wbm_ack_o}, wbm_dat_o);
            end else begin
                item = exp_q.pop_front();
                if ({wbm_err_o, wbm_rty_o, wbm_ack_o} !== item[42:40] ||
                    wbm_dat_o !== item[31:0] || lat != int'(item[39:32])) begin
                    errors++;
                    $display("FAIL resp: got kind=%b dat=%h lat=%0d expected kind=%b dat=%h lat=%0d",
                             {wbm_err_o, wbm_rty_o, wbm_ack_o}, wbm_dat_o, lat,
                             item[42:40], item[31:0], item[39:32]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    logic [NS-1:0]    stb_seen;
    logic [NS-1:0]    we_seen;
    logic [NS*DW-1:0] dat_seen;

    task automatic do_access(input string name, input logic [31:0] adr, input logic [31:0] dat,
                             input logic we, input logic [2:0] kind, input int dslave,
                             input int lat, input logic [3:0] exp_mask);
        logic [31:0] exp_data;
        logic got;
        exp_data = (dslave >= 0) ? rdata(dslave) : exp_held;
        exp_held = exp_data;
        stb_seen = '0;
        we_seen  = '0;
        dat_seen = '0;
        got      = 1'b0;
        @(negedge clk);
        adr_m = adr; dat_m = dat; we_m = we; cyc = 1'b1; stb = 1'b1;
        req_cnt = cyc_cnt;
        exp_q.push_back({kind, 8'(lat), exp_data});
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wbs_stb_o != '0) begin
                stb_seen = stb_seen | wbs_stb_o;
                we_seen  = wbs_we_o;
                dat_seen = wbs_dat_o;
            end
            if (wbm_ack_o || wbm_err_o || wbm_rty_o) begin
                got = 1'b1;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we_m = 1'b0;
        chk({name, "_done"}, 128'(got), 128'(1'b1));
        chk({name, "_stb"}, 128'(stb_seen), 128'(exp_mask));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [NS*DW-1:0] wexp;
        for (int i = 0; i < NS; i++) mode[i] = 3'd0;

        repeat (2) @(negedge clk);
        chk("rst_ack",   128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'(0));
        chk("rst_dat",   128'(wbm_dat_o), 128'(0));
        chk("rst_stb",   128'(wbs_stb_o), 128'(0));
        chk("rst_cyc",   128'(wbs_cyc_o), 128'(0));
        chk("rst_state", 128'(dbg_state), 128'(0));
        rst = 1'b0;

        // 1: read slave 0, zero-wait ack
        do_access("t1_read", 32'h0000_1004, 32'h0, 1'b0, K_ACK, 0, 2, 4'b0001);

        // 2: write slave 3, broadcast data and we
        do_access("t2_write", 32'h0000_0100, 32'hCAFE_F00D, 1'b1, K_ACK, 3, 2, 4'b1000);
        wexp = {NS{32'hCAFE_F00D}};
        chk("t2_we",  128'(we_seen), 128'(4'hF));
        chk("t2_dat", 128'(dat_seen), 128'(wexp));

        // 3: unmapped address, data held from previous access
        do_access("t3_unmapped", 32'h7F00_0000, 32'h0, 1'b0, K_ERR, -1, 1, 4'b0000);
`ifdef WB_MUX_ERRLATCH_EN
        chk("t3_cause", 128'(err_cause), 128'(2));
        chk("t3_eadr",  128'(err_adr), 128'(32'h7F00_0000));
`endif

        // 4: silent slave 2, timeout after 8 BUSY cycles
        mode[2] = 3'd1;
        do_access("t4_timeout", 32'h0000_3000, 32'h0, 1'b0, K_ERR, -1, 9, 4'b0100);
        chk("t4_stb_drop", 128'(wbs_stb_o), 128'(0));
`ifdef WB_MUX_ERRLATCH_EN
        chk("t4_cause", 128'(err_cause), 128'(3));
        chk("t4_eadr",  128'(err_adr), 128'(32'h0000_3000));
`endif

        // 5: overlap resolves to slave 1; err beats ack; stray ack on slave 0 ignored
        mode[1] = 3'd2;
        spur_ack = 4'b0001;
        do_access("t5_err_ack", 32'h0000_2010, 32'h0, 1'b0, K_ERR, 1, 2, 4'b0010);
        spur_ack = '0;
`ifdef WB_MUX_ERRLATCH_EN
        chk("t5_cause", 128'(err_cause), 128'(1));
`endif

        // retry from slave 2
        mode[2] = 3'd3;
        do_access("t6_retry", 32'h0000_3004, 32'h0, 1'b0, K_RTY, 2, 2, 4'b0100);

        // slave 0 with two wait states
        mode[0] = 3'd4;
        do_access("t7_wait", 32'h0000_1FFC, 32'h0, 1'b0, K_ACK, 0, 4, 4'b0001);

        // abort: master drops cyc while BUSY, no response expected
        mode[2] = 3'd1;
        @(negedge clk);
        adr_m = 32'h0000_3000; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(negedge clk);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        chk("t8_abort_stb",   128'(wbs_stb_o), 128'(0));
        chk("t8_abort_state", 128'(dbg_state), 128'(0));
        repeat (2) @(negedge clk);

        // reset in the middle of a BUSY access
        @(negedge clk);
        adr_m = 32'h0000_3000; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        chk("t9_busy_stb", 128'(wbs_stb_o), 128'(4'b0100));
        #2 rst = 1'b1;
        #1;
        chk("t9_rst_stb",   128'(wbs_stb_o), 128'(0));
        chk("t9_rst_cyc",   128'(wbs_cyc_o), 128'(0));
        chk("t9_rst_dat",   128'(wbm_dat_o), 128'(0));
        chk("t9_rst_resp",  128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'(0));
        chk("t9_rst_state", 128'(dbg_state), 128'(0));
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; rst = 1'b0;
        exp_held = '0;

        // normal access after reset
        mode[0] = 3'd0;
        do_access("t10_after_rst", 32'h0000_1004, 32'h0, 1'b0, K_ACK, 0, 2, 4'b0001);

        repeat (3) @(negedge clk);
        chk("queue_empty", 128'(exp_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
